csa_accumulator: RTL and testbench

//   Frame accumulator directly downstream of the 16-bit carry-select adder (csa).

---
 rtl/csa_accumulator.sv | 144 ++++++++++++++
 tb/tb_csa_accumulator.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/csa_accumulator.sv
// Frame accumulator built on a 16-bit carry-select adder. It sums NUM_WORDS operands
// per frame, counts adder carry-outs for full precision, and hands the result over valid/ready.

module csa_adder16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    function automatic logic [4:0] add4(input logic [3:0] a, input logic [3:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {4'b0000, c};
    endfunction

    logic [4:0] blk_carry_s;
    assign blk_carry_s[0] = cin_i;

    // Each nibble precomputes both carry-in cases; the incoming carry picks one.
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_blk
            logic [4:0] r0_s;
            logic [4:0] r1_s;
            assign r0_s = add4(a_i[4*g +: 4], b_i[4*g +: 4], 1'b0);
            assign r1_s = add4(a_i[4*g +: 4], b_i[4*g +: 4], 1'b1);
            assign sum_o[4*g +: 4]  = blk_carry_s[g] ? r1_s[3:0] : r0_s[3:0];
            assign blk_carry_s[g+1] = blk_carry_s[g] ? r1_s[4]   : r0_s[4];
        end
    endgenerate

    assign cout_o = blk_carry_s[4];

endmodule

module csa_accumulator #(
    parameter int NUM_WORDS = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [15:0]      out_sum_o,
    output logic [CNT_W-1:0] out_carries_o,
    output logic             out_ovf_o
);

    typedef enum logic [0:0] {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [CNT_W-1:0] carries_q, carries_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             ovf_q, ovf_d;

    logic [15:0]      add_sum_s;
    logic             add_cout_s;
    logic             accept_s;

    csa_adder16 u_csa (
        .a_i    (acc_q),
        .b_i    (in_data_i),
        .cin_i  (1'b0),
        .sum_o  (add_sum_s),
        .cout_o (add_cout_s)
    );

    assign in_ready_o = (state_q == ST_ACC) & ~flush_i & ~rst_i;
    assign accept_s   = in_valid_i & in_ready_o;

    // Next-state and datapath update for the collect/present cycle.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        carries_d  = carries_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            ST_ACC: begin
                if (flush_i) begin
                    acc_d      = 16'h0000;
                    carries_d  = '0;
                    word_cnt_d = '0;
                end else if (accept_s) begin
                    acc_d     = add_sum_s;
                    carries_d = carries_q + {{(CNT_W-1){1'b0}}, add_cout_s};
                    if (word_cnt_q == LAST_IDX) begin
                        word_cnt_d = '0;
                        state_d    = ST_HOLD;
                    end else begin
                        word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    acc_d     = 16'h0000;
                    carries_d = '0;
                    state_d   = ST_ACC;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d    = ST_ACC;
                acc_d      = 16'h0000;
                carries_d  = '0;
                word_cnt_d = '0;
            end
        endcase
        ovf_d = (carries_d != '0);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_ACC;
            acc_q      <= 16'h0000;
            carries_q  <= '0;
            word_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            carries_q  <= carries_d;
            word_cnt_q <= word_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid_o   = (state_q == ST_HOLD);
    assign out_sum_o     = acc_q;
    assign out_carries_o = carries_q;
    assign out_ovf_o     = ovf_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator (NUM_WORDS=4, CNT_W=8): frame table plus
// hand-written sequences for back-pressure, flush and mid-frame reset.

module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [15:0] in_data, out_sum;
    logic [7:0]  out_carries;

    int n_cmp  = 0;
    int n_fail = 0;

    csa_accumulator #(.NUM_WORDS(4), .CNT_W(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_sum_o     (out_sum),
        .out_carries_o (out_carries),
        .out_ovf_o     (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w [4];
        logic [15:0] exp_sum;
        logic [7:0]  exp_car;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer n words back-to-back; each is driven at a negedge and accepted at the next posedge.
    task automatic send_words(input logic [15:0] w [4], input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("in_ready_before_word", {31'd0, in_ready}, 32'd1);
            check("no_early_valid", {31'd0, out_valid}, 32'd0);
            in_valid = 1'b1;
            in_data  = w[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
    endtask

    task automatic check_result(input string tag, input logic [15:0] s, input logic [7:0] c, input logic o);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"}, {16'd0, out_sum}, {16'd0, s});
        check({tag, "_carries"}, {24'd0, out_carries}, {24'd0, c});
        check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, o});
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid_low", {31'd0, out_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
        check("drain_sum_cleared", {16'd0, out_sum}, 32'd0);
    endtask

    logic [15:0] wv [4];

    initial begin
        vecs[0].w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        vecs[0].exp_sum = 16'h000A; vecs[0].exp_car = 8'd0; vecs[0].exp_ovf = 1'b0;
        vecs[1].w = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[1].exp_sum = 16'hFFFC; vecs[1].exp_car = 8'd3; vecs[1].exp_ovf = 1'b1;
        vecs[2].w = '{16'h8000, 16'h8000, 16'h0001, 16'h0001};
        vecs[2].exp_sum = 16'h0002; vecs[2].exp_car = 8'd1; vecs[2].exp_ovf = 1'b1;
        vecs[3].w = '{16'h1234, 16'h4321, 16'hAAAA, 16'h5555};
        vecs[3].exp_sum = 16'h5554; vecs[3].exp_car = 8'd1; vecs[3].exp_ovf = 1'b1;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_sum", {16'd0, out_sum}, 32'd0);
        check("reset_carries", {24'd0, out_carries}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            send_words(vecs[v].w, 4);
            check_result($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_car, vecs[v].exp_ovf);
            drain();
        end

        // Back-pressure: result held, extra words refused.
        wv = '{16'h0010, 16'h0010, 16'h0010, 16'h0010};
        send_words(wv, 4);
        in_valid = 1'b1;
        in_data  = 16'h7777;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_result("hold", 16'h0040, 8'd0, 1'b0);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        drain();
        wv = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
        send_words(wv, 4);
        check_result("after_hold", 16'h0004, 8'd0, 1'b0);
        drain();

        // Flush together with a third word.
        wv = '{16'h1234, 16'h1234, 16'h0000, 16'h0000};
        send_words(wv, 2);
        check("partial_sum", {16'd0, out_sum}, 32'h2468);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        flush    = 1'b1;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_sum", {16'd0, out_sum}, 32'd0);
        wv = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
        send_words(wv, 4);
        check_result("post_flush", 16'h0004, 8'd0, 1'b0);
        drain();

        // Reset mid-frame.
        wv = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
        send_words(wv, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", {16'd0, out_sum}, 32'd0);
        check("midrst_carries", {24'd0, out_carries}, 32'd0);
        wv = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        send_words(wv, 4);
        check_result("post_rst", 16'h0000, 8'd2, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
